// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
//
// Purpose: shared types and constants for the single-port SRAM arbiter.
//   req_e    : requester index order (fetch, load, store); also the bit
//              position of each requester in the valid/grant vectors.
//   N_REQ    : number of requesters sharing the SRAM.
//   WORD_LSB : lowest byte-address bit that selects a 64-bit SRAM word.
// -----------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int N_REQ    = 3;
  localparam int WORD_LSB = 3;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'd0,
    REQ_LOAD  = 2'd1,
    REQ_STORE = 2'd2
  } req_e;

endpackage : sram_arb_pkg

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purpose: N-way round-robin arbiter with a registered priority pointer.
//   The requester at the pointer has the highest priority, then pointer+1,
//   pointer+2, ... (mod N). After a grant to index g the pointer moves to
//   (g+1) mod N; with no grant it holds. Pointer values >= N are treated as 0.
//
// Ports:
//   clk    in   clock
//   rstn   in   synchronous active-low reset (pointer -> 0)
//   req_i  in   N request bits
//   gnt_o  out  N grant bits, one-hot when any request is set, else zero
//   ptr_o  out  current registered pointer
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] ptr_eff;
  logic [N-1:0]  gnt;
  logic [PW-1:0] gnt_idx;
  logic          gnt_found;

  // Out-of-range pointer values cannot occur after reset, but map them to
  // 0 so a corrupted pointer still yields a legal priority order.
  assign ptr_eff = (int'(ptr_q) >= N) ? '0 : ptr_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values and the update order cannot matter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Grant: scan from the pointer upward and take the first request.
  // NOTE: every variable driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit keeps ptr+i from wrapping before the mod-N fold.
      sum = {1'b0, ptr_eff} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (!gnt_found && req_i[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
        gnt_found = 1'b1;
      end
    end
  end

  // Next state: step past the granted requester, otherwise hold.
  always_comb begin
    ptr_d = ptr_eff;
    if (gnt_found) begin
      if (int'(gnt_idx) == N - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + 1'b1;
      end
    end
  end

  // Outputs.
  always_comb begin
    gnt_o = gnt;
    ptr_o = ptr_q;
  end

endmodule : rr_arbiter

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Purpose: shares one single-port (1RW) 64-bit SRAM between instruction
//   fetch (read), data load (read) and data store (write). One requester is
//   granted per cycle in round-robin order; read data comes back one cycle
//   after the grant on the channel of the requester that issued the read.
//
// Parameters:
//   ADDR_WIDTH : SRAM word-index width (64-bit words)
//   XLEN       : byte-address width of the request ports
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   fetch_a_*                 fetch request (valid/ready/addr, 4-byte aligned)
//   fetch_d_valid/_data       fetch response, 32-bit word selected by addr[2]
//   load_a_*                  load request (valid/ready/addr)
//   load_d_valid/_data        load response, full 64-bit word
//   store_*                   store request (valid/ready/addr/data/strb)
//   sram_req/_we/_addr        SRAM command, word index = addr[ADDR_WIDTH+2:3]
//   sram_wdata/_wmask         SRAM write data and byte mask (0 unless store)
//   sram_rdata                SRAM read data, valid 1 cycle after a read
//   conflict_cnt              saturating count of cycles with >= 2 valids
//
// Configuration:
//   SRAM_ARB_PERF_EN  when defined, builds the conflict counter; otherwise
//                     conflict_cnt is tied to 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int XLEN       = 64
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  fetch_a_valid,
  output logic                  fetch_a_ready,
  input  logic [XLEN-1:0]       fetch_a_addr,
  output logic                  fetch_d_valid,
  output logic [31:0]           fetch_d_data,

  input  logic                  load_a_valid,
  output logic                  load_a_ready,
  input  logic [XLEN-1:0]       load_a_addr,
  output logic                  load_d_valid,
  output logic [63:0]           load_d_data,

  input  logic                  store_valid,
  output logic                  store_ready,
  input  logic [XLEN-1:0]       store_addr,
  input  logic [63:0]           store_data,
  input  logic [7:0]            store_strb,

  output logic                  sram_req,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [63:0]           sram_wdata,
  output logic [7:0]            sram_wmask,
  input  logic [63:0]           sram_rdata,

  output logic [31:0]           conflict_cnt
);

  localparam int ADDR_MSB = ADDR_WIDTH + WORD_LSB - 1;

  logic [N_REQ-1:0] valid_v;
  logic [N_REQ-1:0] req_v;
  logic [N_REQ-1:0] gnt_v;
  logic [1:0]       arb_ptr;

  logic rsp_fetch_q, rsp_fetch_d;
  logic rsp_load_q,  rsp_load_d;
  logic rsp_bo_q,    rsp_bo_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_v            = '0;
    valid_v[REQ_FETCH] = fetch_a_valid;
    valid_v[REQ_LOAD]  = load_a_valid;
    valid_v[REQ_STORE] = store_valid;
  end

  // Masking requests with rstn keeps every ready and sram_req low while
  // reset is held, even though the reset itself only acts at the edge.
  assign req_v = valid_v & {N_REQ{rstn}};

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .clk   (clk),
    .rstn  (rstn),
    .req_i (req_v),
    .gnt_o (gnt_v),
    .ptr_o (arb_ptr)
  );

  assign fetch_a_ready = gnt_v[REQ_FETCH];
  assign load_a_ready  = gnt_v[REQ_LOAD];
  assign store_ready   = gnt_v[REQ_STORE];

  // ---------------------------------------------------------------------------
  // SRAM drive
  // ---------------------------------------------------------------------------
  assign sram_req   = |gnt_v;
  assign sram_we    = gnt_v[REQ_STORE];
  assign sram_wdata = store_data;
  // A read must never carry a stale store mask into the macro.
  assign sram_wmask = gnt_v[REQ_STORE] ? store_strb : 8'h00;

  always_comb begin
    sram_addr = '0;
    if (gnt_v[REQ_FETCH]) begin
      sram_addr = fetch_a_addr[ADDR_MSB:WORD_LSB];
    end else if (gnt_v[REQ_LOAD]) begin
      sram_addr = load_a_addr[ADDR_MSB:WORD_LSB];
    end else if (gnt_v[REQ_STORE]) begin
      sram_addr = store_addr[ADDR_MSB:WORD_LSB];
    end
  end

  // ---------------------------------------------------------------------------
  // Read response pipeline: remember who read and which fetch half was asked
  // for, then steer the SRAM output one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_fetch_d = gnt_v[REQ_FETCH];
    rsp_load_d  = gnt_v[REQ_LOAD];
    rsp_bo_d    = gnt_v[REQ_FETCH] ? fetch_a_addr[2] : rsp_bo_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_fetch_q <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_bo_q    <= 1'b0;
    end else begin
      rsp_fetch_q <= rsp_fetch_d;
      rsp_load_q  <= rsp_load_d;
      rsp_bo_q    <= rsp_bo_d;
    end
  end

  // Gating with rstn drops a response whose read was granted just before
  // reset was asserted: the flop still holds it during the first reset cycle.
  assign fetch_d_valid = rsp_fetch_q & rstn;
  assign load_d_valid  = rsp_load_q & rstn;
  assign fetch_d_data  = rsp_bo_q ? sram_rdata[63:32] : sram_rdata[31:0];
  assign load_d_data   = sram_rdata;

  // ---------------------------------------------------------------------------
  // Conflict counter
  // ---------------------------------------------------------------------------
`ifdef SRAM_ARB_PERF_EN
  logic        multi_valid;
  logic [31:0] conflict_q;
  logic [31:0] conflict_d;

  // Counts raw valids, not grants: this measures contention the core sees.
  assign multi_valid = (fetch_a_valid & load_a_valid) |
                       (fetch_a_valid & store_valid)  |
                       (load_a_valid  & store_valid);

  always_comb begin
    conflict_d = conflict_q;
    if (multi_valid && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 32'd0;
`endif

  // Address bits outside the SRAM word index, and the pointer, which is
  // exposed by the arbiter for observation only.
  logic unused_bits;
  assign unused_bits = ^{fetch_a_addr[XLEN-1:ADDR_MSB+1], fetch_a_addr[1:0],
                         load_a_addr[XLEN-1:ADDR_MSB+1],  load_a_addr[WORD_LSB-1:0],
                         store_addr[XLEN-1:ADDR_MSB+1],   store_addr[WORD_LSB-1:0],
                         arb_ptr};

endmodule : sram_port_arbiter

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Self-checking bench for sram_port_arbiter. A behavioural 1RW SRAM with
// 1-cycle read latency sits on the SRAM port. A reference memory is updated
// from the store stimulus when a store is accepted; expected read responses
// are computed from it and queued on acceptance, then popped and compared
// when the DUT raises a d_valid. Define SRAM_ARB_PERF_EN for both the DUT and
// the bench to exercise the conflict counter.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam int AW = 20;
  localparam int XL = 64;

`ifdef SRAM_ARB_PERF_EN
  localparam logic PERF_EN = 1'b1;
`else
  localparam logic PERF_EN = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic          fetch_a_valid, fetch_a_ready, fetch_d_valid;
  logic [XL-1:0] fetch_a_addr;
  logic [31:0]   fetch_d_data;
  logic          load_a_valid, load_a_ready, load_d_valid;
  logic [XL-1:0] load_a_addr;
  logic [63:0]   load_d_data;
  logic          store_valid, store_ready;
  logic [XL-1:0] store_addr;
  logic [63:0]   store_data;
  logic [7:0]    store_strb;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [63:0]   sram_wdata;
  logic [7:0]    sram_wmask;
  logic [63:0]   sram_rdata;
  logic [31:0]   conflict_cnt;

  logic [2:0]    rdy_v;
  assign rdy_v = {store_ready, load_a_ready, fetch_a_ready};

  int checks = 0;
  int errors = 0;

  logic [63:0] sram_mem [0:1023];
  logic [63:0] ref_mem  [0:1023];
  logic        mem_init;
  logic [31:0] exp_fetch_q [$];
  logic [63:0] exp_load_q  [$];

  sram_port_arbiter #(
    .ADDR_WIDTH (AW),
    .XLEN       (XL)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .fetch_a_valid (fetch_a_valid),
    .fetch_a_ready (fetch_a_ready),
    .fetch_a_addr  (fetch_a_addr),
    .fetch_d_valid (fetch_d_valid),
    .fetch_d_data  (fetch_d_data),
    .load_a_valid  (load_a_valid),
    .load_a_ready  (load_a_ready),
    .load_a_addr   (load_a_addr),
    .load_d_valid  (load_d_valid),
    .load_d_data   (load_d_data),
    .store_valid   (store_valid),
    .store_ready   (store_ready),
    .store_addr    (store_addr),
    .store_data    (store_data),
    .store_strb    (store_strb),
    .sram_req      (sram_req),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_wmask    (sram_wmask),
    .sram_rdata    (sram_rdata),
    .conflict_cnt  (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(int i);
    if (i == 32'h200) return 64'hAABBCCDD_11223344;
    if (i == 8)       return 64'h0;
    return {16'hFACE, i[15:0], 16'hBEEF, ~i[15:0]};
  endfunction

  function automatic logic [63:0] expand_mask(logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  // Behavioural 1RW SRAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= init_word(i);
    end else if (sram_req) begin
      if (sram_we) begin
        sram_mem[sram_addr[9:0]] <= (sram_mem[sram_addr[9:0]] & ~expand_mask(sram_wmask)) |
                                    (sram_wdata & expand_mask(sram_wmask));
      end else begin
        sram_rdata <= sram_mem[sram_addr[9:0]];
      end
    end
  end

  // Response side of the scoreboard plus per-cycle port sanity.
  always @(negedge clk) begin : monitor
    logic [31:0] ef;
    logic [63:0] el;
    if (fetch_d_valid === 1'b1) begin
      checks++;
      if (exp_fetch_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_rsp_unexpected: got data %h, required no response", fetch_d_data);
      end else begin
        ef = exp_fetch_q.pop_front();
        if (fetch_d_data !== ef) begin
          errors++;
          $display("FAIL fetch_rsp_data: got %h, required %h", fetch_d_data, ef);
        end
      end
    end
    if (load_d_valid === 1'b1) begin
      checks++;
      if (exp_load_q.size() == 0) begin
        errors++;
        $display("FAIL load_rsp_unexpected: got data %h, required no response", load_d_data);
      end else begin
        el = exp_load_q.pop_front();
        if (load_d_data !== el) begin
          errors++;
          $display("FAIL load_rsp_data: got %h, required %h", load_d_data, el);
        end
      end
    end
    checks++;
    if ($countones(rdy_v) > 1 || sram_req !== (|rdy_v) || sram_we !== store_ready ||
        (store_ready !== 1'b1 && sram_wmask !== 8'h00)) begin
      errors++;
      $display("FAIL sram_drive: got ready=%b req=%b we=%b wmask=%h, required one-hot ready, req=|ready, we=store_ready, wmask=0 unless store",
               rdy_v, sram_req, sram_we, sram_wmask);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons here)
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Request side of the scoreboard: called at the sampling point of a cycle.
  task automatic record_accepts();
    logic [63:0] w;
    logic [63:0] m;
    if (fetch_a_valid && fetch_a_ready) begin
      w = ref_mem[fetch_a_addr[12:3]];
      exp_fetch_q.push_back(fetch_a_addr[2] ? w[63:32] : w[31:0]);
    end
    if (load_a_valid && load_a_ready) begin
      exp_load_q.push_back(ref_mem[load_a_addr[12:3]]);
    end
    if (store_valid && store_ready) begin
      m = expand_mask(store_strb);
      ref_mem[store_addr[12:3]] = (ref_mem[store_addr[12:3]] & ~m) | (store_data & m);
    end
  endtask

  task automatic idle_inputs();
    fetch_a_valid = 1'b0;
    load_a_valid  = 1'b0;
    store_valid   = 1'b0;
  endtask

  // Holds reset across two edges with no requests, returns just after an
  // edge with rstn released.
  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    fetch_a_valid = 1'b1;
    load_a_valid  = 1'b1;
    store_valid   = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy_v !== 3'b000 || sram_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got ready=%b req=%b, required 000/0", rdy_v, sram_req);
    end
    checks++;
    if (fetch_d_valid !== 1'b0 || load_d_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_dvalid: got fetch=%b load=%b, required 0/0", fetch_d_valid, load_d_valid);
    end
    checks++;
    if (conflict_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_conflict: got %0d, required 0", conflict_cnt);
    end
    next_cycle();
    idle_inputs();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (sram_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req: got %b, required 0", sram_req);
    end
  endtask

  task automatic test_single_fetch();
    next_cycle();
    fetch_a_valid = 1'b1;
    fetch_a_addr  = 64'h1004;
    @(negedge clk);
    checks++;
    if (fetch_a_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_fetch_ready: got %b, required 1", fetch_a_ready);
    end
    record_accepts();
    next_cycle();
    fetch_a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_d_valid !== 1'b1 || fetch_d_data !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL single_fetch_data: got valid=%b data=%h, required 1/aabbccdd", fetch_d_valid, fetch_d_data);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (fetch_d_valid !== 1'b0 || exp_fetch_q.size() != 0) begin
      errors++;
      $display("FAIL single_fetch_once: got valid=%b pending=%0d, required 0/0", fetch_d_valid, exp_fetch_q.size());
    end
  endtask

  task automatic test_contention();
    logic [2:0] exp_v;
    apply_reset();
    fetch_a_valid = 1'b1;
    fetch_a_addr  = 64'h1000;
    load_a_valid  = 1'b1;
    load_a_addr   = 64'h1008;
    store_valid   = 1'b1;
    store_addr    = 64'h80;
    store_data    = 64'hDEADBEEF_CAFEF00D;
    store_strb    = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp_v = 3'(1 << (i % 3));
      checks++;
      if (rdy_v !== exp_v) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got %b, required %b", i, rdy_v, exp_v);
      end
      record_accepts();
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (conflict_cnt !== (PERF_EN ? 32'd9 : 32'd0)) begin
      errors++;
      $display("FAIL contention_conflict: got %0d, required %0d", conflict_cnt, PERF_EN ? 9 : 0);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (exp_fetch_q.size() != 0 || exp_load_q.size() != 0) begin
      errors++;
      $display("FAIL contention_drain: got pending fetch=%0d load=%0d, required 0/0",
               exp_fetch_q.size(), exp_load_q.size());
    end
  endtask

  task automatic test_masked_store_load();
    next_cycle();
    store_valid = 1'b1;
    store_addr  = 64'h40;
    store_data  = 64'h01234567_89ABCDEF;
    store_strb  = 8'h0F;
    @(negedge clk);
    checks++;
    if (store_ready !== 1'b1) begin
      errors++;
      $display("FAIL masked_store_ready: got %b, required 1", store_ready);
    end
    record_accepts();
    next_cycle();
    store_valid  = 1'b0;
    load_a_valid = 1'b1;
    load_a_addr  = 64'h40;
    @(negedge clk);
    checks++;
    if (load_a_ready !== 1'b1) begin
      errors++;
      $display("FAIL masked_load_ready: got %b, required 1", load_a_ready);
    end
    record_accepts();
    next_cycle();
    load_a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (load_d_valid !== 1'b1 || load_d_data !== 64'h00000000_89ABCDEF) begin
      errors++;
      $display("FAIL masked_load_data: got valid=%b data=%h, required 1/0000000089abcdef", load_d_valid, load_d_data);
    end
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    load_a_valid = 1'b1;
    load_a_addr  = 64'h1008;
    @(negedge clk);
    checks++;
    if (load_a_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_load_ready: got %b, required 1", load_a_ready);
    end
    // Reset follows immediately, so this read is expected to vanish.
    next_cycle();
    rstn          = 1'b0;
    fetch_a_valid = 1'b1;
    fetch_a_addr  = 64'h1000;
    store_valid   = 1'b1;
    @(negedge clk);
    checks++;
    if (load_d_valid !== 1'b0 || rdy_v !== 3'b000 || sram_req !== 1'b0) begin
      errors++;
      $display("FAIL midreset_n1: got dvalid=%b ready=%b req=%b, required 0/000/0", load_d_valid, rdy_v, sram_req);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (load_d_valid !== 1'b0 || rdy_v !== 3'b000 || conflict_cnt !== 32'd0) begin
      errors++;
      $display("FAIL midreset_n2: got dvalid=%b ready=%b conflict=%0d, required 0/000/0", load_d_valid, rdy_v, conflict_cnt);
    end
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy_v !== 3'b001) begin
      errors++;
      $display("FAIL midreset_first_grant: got %b, required 001", rdy_v);
    end
    record_accepts();
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    checks++;
    if (exp_fetch_q.size() != 0 || exp_load_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_drain: got pending fetch=%0d load=%0d, required 0/0",
               exp_fetch_q.size(), exp_load_q.size());
    end
  endtask

  task automatic test_pointer_priority();
    apply_reset();
    load_a_valid = 1'b1;
    load_a_addr  = 64'h1008;
    @(negedge clk);
    checks++;
    if (rdy_v !== 3'b010) begin
      errors++;
      $display("FAIL prio_setup_load: got %b, required 010", rdy_v);
    end
    record_accepts();
    next_cycle();
    store_valid = 1'b1;
    store_addr  = 64'h88;
    store_data  = 64'h11112222_33334444;
    store_strb  = 8'hF0;
    @(negedge clk);
    checks++;
    if (rdy_v !== 3'b100) begin
      errors++;
      $display("FAIL prio_store_first: got %b, required 100", rdy_v);
    end
    record_accepts();
    next_cycle();
    store_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy_v !== 3'b010) begin
      errors++;
      $display("FAIL prio_load_next: got %b, required 010", rdy_v);
    end
    record_accepts();
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (conflict_cnt !== (PERF_EN ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL prio_conflict: got %0d, required %0d", conflict_cnt, PERF_EN ? 1 : 0);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (exp_fetch_q.size() != 0 || exp_load_q.size() != 0) begin
      errors++;
      $display("FAIL prio_drain: got pending fetch=%0d load=%0d, required 0/0",
               exp_fetch_q.size(), exp_load_q.size());
    end
  endtask

  initial begin
    rstn          = 1'b0;
    mem_init      = 1'b1;
    fetch_a_valid = 1'b0;
    fetch_a_addr  = '0;
    load_a_valid  = 1'b0;
    load_a_addr   = '0;
    store_valid   = 1'b0;
    store_addr    = '0;
    store_data    = '0;
    store_strb    = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    next_cycle();
    mem_init = 1'b0;

    test_reset();
    test_single_fetch();
    test_contention();
    test_masked_store_load();
    test_reset_mid_read();
    test_pointer_priority();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sram_port_arbiter

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port (1RW) 64-bit SRAM between three requesters: instruction fetch (read), data load (read) and data store (write).
- Replaces the ideal multi-port fake memory in the system top, so the core runs against a realistic single-port macro.
- Grants at most one requester per cycle using round-robin arbitration.
- Returns read data after a fixed 1-cycle SRAM latency to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 20, SRAM word-index width (64-bit words).
- XLEN, 64, byte-address width of the request ports.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- fetch_a_valid  in  1  fetch request valid
- fetch_a_ready  out  1  fetch request accepted
- fetch_a_addr  in  XLEN  fetch byte address, 4-byte aligned
- fetch_d_valid  out  1  fetch response valid
- fetch_d_data  out  32  selected instruction word
- load_a_valid  in  1  load request valid
- load_a_ready  out  1  load request accepted
- load_a_addr  in  XLEN  load byte address
- load_d_valid  out  1  load response valid
- load_d_data  out  64  full SRAM word
- store_valid  in  1  store request valid
- store_ready  out  1  store accepted
- store_addr  in  XLEN  store byte address
- store_data  in  64  store data
- store_strb  in  8  byte enables
- sram_req  out  1  SRAM access this cycle
- sram_we  out  1  write (1) or read (0)
- sram_addr  out  ADDR_WIDTH  word index, taken from addr[ADDR_WIDTH+2:3]
- sram_wdata  out  64  write data
- sram_wmask  out  8  byte write mask
- sram_rdata  in  64  read data, valid 1 cycle after a read request
- conflict_cnt  out  32  cycles where two or more requesters were valid (see Optional Feature)

Behaviour:
- Requester index order: 0 fetch, 1 load, 2 store.
- State: 2-bit round-robin pointer `ptr`. The requester at `ptr` has the highest priority, then ptr+1, then ptr+2 (mod 3).
- Grant:
  - Combinational from the valids and `ptr`.
  - Exactly one grant per cycle when any requester is valid, otherwise none.
  - x_a_ready equals grant[x]. A transfer happens when valid and ready are both high.
  - Requesters hold valid and address/data stable until ready.
- Pointer update: on a grant to index g, `ptr` becomes (g+1) mod 3. With no grant, `ptr` holds. Value 3 is illegal; the RTL maps it to 0.
- SRAM drive:
  - sram_req = any grant; sram_we = grant[store].
  - sram_addr is muxed from the granted address.
  - sram_wdata and sram_wmask come from the store port, with the mask forced to 0 when the store is not granted.
- Read response pipeline:
  - Registered `rsp_fetch`, `rsp_load` and `rsp_bo` (fetch addr[2]) are captured on a read grant.
  - Next cycle, x_d_valid = 1 for exactly one cycle.
  - fetch_d_data = rsp_bo ? sram_rdata[63:32] : sram_rdata[31:0]; load_d_data = sram_rdata.
  - The d channels have no backpressure; responses are always accepted.
- Latency: request to response is 1 cycle. Sustained throughput is 1 access per cycle in aggregate. Under full contention each requester gets 1 access per 3 cycles.
- Stores produce no response.
- Ordering: a store granted in cycle N is visible to a read granted in cycle N+1 or later. Same-cycle ordering between load and store is the core's responsibility.
- Reset (rstn low at a clk edge):
  - `ptr` resets to 0.
  - fetch_d_valid, load_d_valid and the rsp_* registers reset to 0.
  - conflict_cnt resets to 0.
  - While rstn is low, all a_ready outputs and sram_req are forced to 0.
  - A read granted in the cycle before reset produces no response, i.e. d_valid stays 0.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- Defined: conflict_cnt increments by 1 on every non-reset cycle with two or more of the three valids high. It saturates at 0xFFFFFFFF.
- Undefined: conflict_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Package sram_arb_pkg holds:
  - enum req_e {REQ_FETCH=0, REQ_LOAD=1, REQ_STORE=2}
  - N_REQ=3
  - WORD_LSB=3
- Sub-module rr_arbiter: parameter N; inputs req[N]; outputs one-hot gnt[N] and the registered pointer; carries clk and rstn.
- The top module holds the muxing, the response pipeline and the counter.

Test Plan:
- Single fetch: mem[0x200]=0xAABBCCDD_11223344; fetch_a_addr=0x1004 → fetch_a_ready in the same cycle; next cycle fetch_d_valid=1, fetch_d_data=0xAABBCCDD.
- Full contention: all three valid continuously after reset → grant order fetch, load, store, fetch, ... Each ready is high 1 cycle in 3, and there are no double grants.
- Masked store then load:
  - mem[0x8]=0.
  - Store addr 0x40, data 0x0123456789ABCDEF, strb 0x0F.
  - Load 0x40 in the next cycle → load_d_data=0x0000000089ABCDEF.
- Reset mid-read: load granted in cycle N, rstn=0 in cycle N+1 → load_d_valid=0 in N+1 and N+2; all readies are 0 during reset. The first grant after reset goes to fetch when all are valid.
- Pointer priority: load and store valid with ptr=2 → store is granted, then load in the next cycle. With SRAM_ARB_PERF_EN, conflict_cnt=1 afterwards; without it, conflict_cnt=0.
